id_operand_fwd_unit: RTL

//  Parametrised decode-stage operand unit for the 5-stage LoongArch pipeline.
//  - Holds the ID pipeline register and its valid/allow handshake.
//  - Resolves both source operands by forwarding from NSTG downstream stages instead of stalling
//    on every RAW hazard; stalls only when the matching producer's data is not yet ready (load-use).
//  - Captures resolved operands while ID is held, so producers that retire during a hold are not lost.
//  - Sits between the IF->ID register input and the decoder/EX input.

---
 rtl/id_operand_fwd_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/id_operand_fwd_unit.sv
// Decode-stage pipeline register with operand forwarding from NSTG downstream stages.
// Stalls only on a matching producer whose result is not final; resolved operands are captured while ID is held.
module id_operand_fwd_unit #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NSTG = 3,
    parameter int PL_W = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_allow,
    input  logic [PL_W-1:0]      in_payload,
    output logic                 out_valid,
    input  logic                 out_allow,
    output logic [PL_W-1:0]      id_payload,
    input  logic                 re1,
    input  logic                 re2,
    input  logic [AW-1:0]        raddr1,
    input  logic [AW-1:0]        raddr2,
    output logic [AW-1:0]        rf_raddr1,
    output logic [AW-1:0]        rf_raddr2,
    input  logic [DW-1:0]        rf_rdata1,
    input  logic [DW-1:0]        rf_rdata2,
    input  logic [NSTG-1:0]      fwd_valid,
    input  logic [NSTG-1:0]      fwd_we,
    input  logic [NSTG*AW-1:0]   fwd_waddr,
    input  logic [NSTG*DW-1:0]   fwd_data,
    input  logic [NSTG-1:0]      fwd_ready,
    output logic [DW-1:0]        src1_data,
    output logic [DW-1:0]        src2_data,
    output logic                 stall,
    output logic [31:0]          stall_cycles
);

    typedef struct packed {
        logic          res;
        logic [DW-1:0] dat;
    } opnd_t;

    // Youngest matching writer wins, even when its result is not final yet.
    function automatic opnd_t resolve(
        input logic              re,
        input logic [AW-1:0]     ra,
        input logic              cv,
        input logic [DW-1:0]     cd,
        input logic [DW-1:0]     rd,
        input logic [NSTG-1:0]   fv,
        input logic [NSTG-1:0]   fwe,
        input logic [NSTG-1:0]   frdy,
        input logic [NSTG*AW-1:0] fa,
        input logic [NSTG*DW-1:0] fd
    );
        opnd_t o;
        logic  hit;
        o.res = 1'b1;
        o.dat = rd;
        hit   = 1'b0;
        if (!re || ra == '0) begin
            o.dat = '0;
        end else if (cv) begin
            o.dat = cd;
        end else begin
            for (int i = 0; i < NSTG; i++) begin
                if (!hit && fv[i] && fwe[i] && fa[i*AW +: AW] == ra) begin
                    hit   = 1'b1;
                    o.dat = fd[i*DW +: DW];
                    o.res = frdy[i];
                end
            end
        end
        return o;
    endfunction

    logic            id_valid_q,     id_valid_d;
    logic [PL_W-1:0] id_payload_q,   id_payload_d;
    logic            cap_v1_q,       cap_v1_d;
    logic            cap_v2_q,       cap_v2_d;
    logic [DW-1:0]   cap_d1_q,       cap_d1_d;
    logic [DW-1:0]   cap_d2_q,       cap_d2_d;
    logic [31:0]     stall_cycles_q, stall_cycles_d;

    opnd_t op1, op2;
    logic  out_fire;
    logic  accept;

    always_comb begin
        op1 = resolve(re1, raddr1, cap_v1_q, cap_d1_q, rf_rdata1,
                      fwd_valid, fwd_we, fwd_ready, fwd_waddr, fwd_data);
        op2 = resolve(re2, raddr2, cap_v2_q, cap_d2_q, rf_rdata2,
                      fwd_valid, fwd_we, fwd_ready, fwd_waddr, fwd_data);
    end

    assign stall        = id_valid_q & ~(op1.res & op2.res);
    assign out_valid    = id_valid_q & ~stall;
    assign out_fire     = out_valid & out_allow;
    assign in_allow     = ~id_valid_q | out_fire;
    assign accept       = in_valid & in_allow;
    assign id_payload   = id_payload_q;
    assign rf_raddr1    = raddr1;
    assign rf_raddr2    = raddr2;
    assign src1_data    = op1.dat;
    assign src2_data    = op2.dat;
    assign stall_cycles = stall_cycles_q;

    always_comb begin
        id_valid_d     = id_valid_q;
        id_payload_d   = id_payload_q;
        cap_v1_d       = cap_v1_q;
        cap_v2_d       = cap_v2_q;
        cap_d1_d       = cap_d1_q;
        cap_d2_d       = cap_d2_q;
        stall_cycles_d = stall_cycles_q;

        if (flush) begin
            id_valid_d = 1'b0;
            cap_v1_d   = 1'b0;
            cap_v2_d   = 1'b0;
        end else if (accept) begin
            id_payload_d = in_payload;
            id_valid_d   = 1'b1;
            cap_v1_d     = 1'b0;
            cap_v2_d     = 1'b0;
        end else if (out_fire) begin
            id_valid_d = 1'b0;
        end

        // Hold each resolved source so a producer retiring during the hold is not lost.
        if (id_valid_q && !out_fire && !flush) begin
            if (!cap_v1_q && op1.res) begin
                cap_v1_d = 1'b1;
                cap_d1_d = op1.dat;
            end
            if (!cap_v2_q && op2.res) begin
                cap_v2_d = 1'b1;
                cap_d2_d = op2.dat;
            end
        end

        if (stall && stall_cycles_q != 32'hFFFF_FFFF)
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid_q     <= 1'b0;
            id_payload_q   <= '0;
            cap_v1_q       <= 1'b0;
            cap_v2_q       <= 1'b0;
            cap_d1_q       <= '0;
            cap_d2_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            id_valid_q     <= id_valid_d;
            id_payload_q   <= id_payload_d;
            cap_v1_q       <= cap_v1_d;
            cap_v2_q       <= cap_v2_d;
            cap_d1_q       <= cap_d1_d;
            cap_d2_q       <= cap_d2_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule
